sp_ram_arb: RTL

Two-port round-robin arbiter and zero-init sequencer placed in front of `sp_ram_wrap`. It shares the single-port 32-bit data RAM between two OBI-style requesters, for example the core data port and the debug/AXI bridge. It also clears every RAM word after reset before any requester is granted, so the banked SRAM macros never return uninitialised data.

---
 rtl/sp_ram_arb_pkg.sv | 17 +
 rtl/rr_arb_2.sv | 35 +++
 rtl/sp_ram_arb.sv | 125 ++++++++++++
 3 files changed

// File: rtl/sp_ram_arb_pkg.sv
// Shared types and helpers for the two-port RAM arbiter and its
// zero-init sequencer.
package sp_ram_arb_pkg;

  localparam int NUM_PORTS = 2;

  typedef enum logic [1:0] {
    RST_WAIT = 2'd0,
    INIT     = 2'd1,
    RUN      = 2'd2
  } sp_ram_arb_state_e;

  function automatic int words(input int ram_size);
    return ram_size / 4;
  endfunction

endpackage

// File: rtl/rr_arb_2.sv
// Two-master round-robin arbiter: combinational grant from req, plus a
// registered pointer to the most recently granted master.
module rr_arb_2
  import sp_ram_arb_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_i,
  input  logic [NUM_PORTS-1:0] req_i,
  output logic [NUM_PORTS-1:0] gnt_o
);

  logic last_gnt_q;
  logic last_gnt_d;

  // NOTE: every output of a combinational block gets a default before any
  // branch, so no path can leave it unassigned and infer a latch.
  always_comb begin
    gnt_o      = '0;
    last_gnt_d = last_gnt_q;
    if (en_i) begin
      if (&req_i) gnt_o = last_gnt_q ? 2'b01 : 2'b10;
      else        gnt_o = req_i;
    end
    if (gnt_o[0])      last_gnt_d = 1'b0;
    else if (gnt_o[1]) last_gnt_d = 1'b1;
  end

  // Pointer starts at master 1 so master 0 wins the first contention.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_gnt_q <= 1'b1;
    else        last_gnt_q <= last_gnt_d;
  end

endmodule

// File: rtl/sp_ram_arb.sv
// Shares one single-port data RAM between two OBI-style requesters and
// zero-fills every word after reset before any requester is granted.
module sp_ram_arb
  import sp_ram_arb_pkg::*;
#(
  parameter int RAM_SIZE   = 32768,
  parameter int ADDR_WIDTH = $clog2(RAM_SIZE),
  parameter int DATA_WIDTH = 32,
  parameter bit INIT_EN    = 1'b1
) (
  input  logic                    clk,
  input  logic                    rstn_i,

  input  logic                    p0_req_i,
  output logic                    p0_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p0_addr_i,
  input  logic                    p0_we_i,
  input  logic [DATA_WIDTH/8-1:0] p0_be_i,
  input  logic [DATA_WIDTH-1:0]   p0_wdata_i,
  output logic                    p0_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p0_rdata_o,

  input  logic                    p1_req_i,
  output logic                    p1_gnt_o,
  input  logic [ADDR_WIDTH-1:0]   p1_addr_i,
  input  logic                    p1_we_i,
  input  logic [DATA_WIDTH/8-1:0] p1_be_i,
  input  logic [DATA_WIDTH-1:0]   p1_wdata_i,
  output logic                    p1_rvalid_o,
  output logic [DATA_WIDTH-1:0]   p1_rdata_o,

  output logic                    ram_en_o,
  output logic [ADDR_WIDTH-1:0]   ram_addr_o,
  output logic                    ram_we_o,
  output logic [DATA_WIDTH/8-1:0] ram_be_o,
  output logic [DATA_WIDTH-1:0]   ram_wdata_o,
  input  logic [DATA_WIDTH-1:0]   ram_rdata_i,

  output logic                    init_done_o
);

  localparam int                    NUM_WORDS = words(RAM_SIZE);
  localparam int                    CNT_W     = ADDR_WIDTH - 2;
  localparam logic [CNT_W-1:0]      LAST_WORD = CNT_W'(NUM_WORDS - 1);
  localparam logic [ADDR_WIDTH-1:0] WORD_MASK = ~ADDR_WIDTH'(3);

  sp_ram_arb_state_e      state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [NUM_PORTS-1:0]   rvalid_q, rvalid_d;
  logic [NUM_PORTS-1:0]   gnt;

  rr_arb_2 u_arb (
    .clk   (clk),
    .rst_n (rstn_i),
    .en_i  (state_q == RUN),
    .req_i ({p1_req_i, p0_req_i}),
    .gnt_o (gnt)
  );

  // The counter parks on the last word once INIT is done; it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      RST_WAIT: state_d = INIT_EN ? INIT : RUN;
      INIT: begin
        if (cnt_q == LAST_WORD) state_d = RUN;
        else                    cnt_d   = cnt_q + CNT_W'(1);
      end
      RUN:     state_d = RUN;
      default: state_d = RST_WAIT;
    endcase
  end

  always_comb begin
    ram_en_o    = 1'b0;
    ram_we_o    = 1'b0;
    ram_be_o    = '0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (state_q == INIT) begin
      ram_en_o   = 1'b1;
      ram_we_o   = 1'b1;
      ram_be_o   = '1;
      ram_addr_o = {cnt_q, 2'b00};
    end else if (gnt[0]) begin
      ram_en_o    = 1'b1;
      ram_we_o    = p0_we_i;
      ram_be_o    = p0_be_i;
      ram_addr_o  = p0_addr_i & WORD_MASK;
      ram_wdata_o = p0_wdata_i;
    end else if (gnt[1]) begin
      ram_en_o    = 1'b1;
      ram_we_o    = p1_we_i;
      ram_be_o    = p1_be_i;
      ram_addr_o  = p1_addr_i & WORD_MASK;
      ram_wdata_o = p1_wdata_i;
    end
  end

  assign rvalid_d = gnt;

  // NOTE: state flops use non-blocking assignment so every flop samples
  // values from before the edge, independent of block evaluation order.
  always_ff @(posedge clk or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q  <= RST_WAIT;
      cnt_q    <= '0;
      rvalid_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
    end
  end

  assign p0_gnt_o    = gnt[0];
  assign p1_gnt_o    = gnt[1];
  assign p0_rvalid_o = rvalid_q[0];
  assign p1_rvalid_o = rvalid_q[1];
  assign p0_rdata_o  = ram_rdata_i;
  assign p1_rdata_o  = ram_rdata_i;
  assign init_done_o = (state_q == RUN);

endmodule
